sumator_multiword_ctrl: RTL and testbench

- Sequencer that performs a wide add, NUM_WORDS × WORD_W bits, on one shared external WORD_W-bit carry-lookahead adder (sumator_16bit).
- Processes one word per cycle, LSW first, and chains the carry through a register between words.
- Accepts operands over a valid/ready input handshake and returns the result over a valid/ready output handshake.
- Sits between the operand source and the adder instance; it owns the adder's inputs.

---
 rtl/sumator_multiword_ctrl.sv | 132 +++++++++++++
 tb/tb_sumator_multiword_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sumator_multiword_ctrl.sv
// sumator_multiword_ctrl: sequences a NUM_WORDS x WORD_W wide add over one shared external
// WORD_W-bit adder, one word per cycle, LSW first, carry chained through a register.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   in_valid/in_ready, a, b, cin   operand handshake and operands
//   out_valid/out_ready, sum, cout result handshake and wide result
//   add_a, add_b, add_cin    drive to the external adder (zero outside RUN)
//   add_sum, add_cout        result from the external adder
//   sub (only with SUMATOR_CTRL_SUB_EN)  1 = compute a - b instead of a + b + cin
//
// Optional feature macro: SUMATOR_CTRL_SUB_EN
module sumator_multiword_ctrl #(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W*NUM_WORDS-1:0] a,
  input  logic [WORD_W*NUM_WORDS-1:0] b,
  input  logic                        cin,
`ifdef SUMATOR_CTRL_SUB_EN
  input  logic                        sub,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W*NUM_WORDS-1:0] sum,
  output logic                        cout,
  output logic [WORD_W-1:0]           add_a,
  output logic [WORD_W-1:0]           add_b,
  output logic                        add_cin,
  input  logic [WORD_W-1:0]           add_sum,
  input  logic                        add_cout
);

  localparam int unsigned TotW = WORD_W * NUM_WORDS;
  localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [TotW-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              cin_q, cin_d, carry_q, carry_d, cout_q, cout_d;
  logic              sub_q, sub_d;
  logic              sub_in;

`ifdef SUMATOR_CTRL_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cin_d   = cin;
          sub_d   = sub_in;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        add_a = a_q[idx_q*WORD_W +: WORD_W];
        // Subtract as a + ~b + 1: invert B and force the first carry-in.
        add_b = sub_q ? ~b_q[idx_q*WORD_W +: WORD_W] : b_q[idx_q*WORD_W +: WORD_W];
        if (idx_q == '0) add_cin = sub_q ? 1'b1 : cin_q;
        else             add_cin = carry_q;
        sum_d[idx_q*WORD_W +: WORD_W] = add_sum;
        carry_d = add_cout;
        if (idx_q == IdxW'(NUM_WORDS - 1)) begin
          cout_d  = add_cout;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_sumator_multiword_ctrl.sv
module tb_sumator_multiword_ctrl;

  localparam int W = 16;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [63:0]   a, b, sum;
  logic [W-1:0]  add_a, add_b, add_sum;
  logic          add_cin, add_cout;
  logic          sub;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external carry-lookahead adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  sumator_multiword_ctrl #(.WORD_W(W), .NUM_WORDS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SUMATOR_CTRL_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  typedef struct packed {
    logic [63:0] s;
    logic        c;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] rec_a[8];
  logic        rec_cin[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive operands for one accept edge and push the reference result.
  task automatic start_op(input logic [63:0] ta, input logic [63:0] tb, input logic tc,
                          input logic ts);
    logic [64:0] r;
    exp_t e;
    if (ts) r = {1'b0, ta} + {1'b0, ~tb} + 65'd1;
    else    r = {1'b0, ta} + {1'b0, tb} + {64'd0, tc};
    e.s = r[63:0];
    e.c = r[64];
    sb.push_back(e);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Called right after the accept edge; returns edges until out_valid (20 = timeout).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (lat < 8) begin
        rec_a[lat]   = add_a;
        rec_cin[lat] = add_cin;
      end
      step();
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    step(); step();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, sum, cout, add_a, add_b, add_cin} !==
        {1'b1, 1'b0, 64'd0, 1'b0, 16'd0, 16'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: rdy=%b ov=%b sum=%h cout=%b aa=%h ab=%h ac=%b", in_ready,
               out_valid, sum, cout, add_a, add_b, add_cin);
    end
  endtask

  task automatic test_ripple();
    int lat;
    exp_t e;
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    wait_result(lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== 4) begin n_err++; $display("FAIL ripple_latency: got %0d want 4", lat); end
    n_cmp++;
    if ({sum, cout} !== {e.s, e.c} || {sum, cout} !== {64'd0, 1'b1}) begin
      n_err++;
      $display("FAIL ripple_result: got %h/%b want %h/%b", sum, cout, e.s, e.c);
    end
    n_cmp++;
    if ({rec_cin[0], rec_cin[1], rec_cin[2], rec_cin[3]} !== 4'b0111) begin
      n_err++;
      $display("FAIL ripple_add_cin: got %b%b%b%b want 0111", rec_cin[0], rec_cin[1],
               rec_cin[2], rec_cin[3]);
    end
    release_result();
  endtask

  task automatic test_mixed();
    int lat;
    exp_t e;
    logic [63:0] opa;
    opa = 64'h1234_5678_9ABC_DEF0;
    start_op(opa, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    wait_result(lat);
    e = sb.pop_front();
    n_cmp++;
    if ({sum, cout} !== {e.s, e.c} || {sum, cout} !== {64'h2222_2222_2222_2212, 1'b0}) begin
      n_err++;
      $display("FAIL mixed_result: got %h/%b want %h/%b", sum, cout, e.s, e.c);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rec_a[i] !== opa[i*16 +: 16]) begin
        n_err++;
        $display("FAIL mixed_add_a[%0d]: got %h want %h", i, rec_a[i], opa[i*16 +: 16]);
      end
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    exp_t e;
    start_op(64'h0000_0001_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
    wait_result(lat);
    e = sb.pop_front();
    a = 64'hDEAD_BEEF_0000_0000; b = 64'h1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({out_valid, in_ready, sum, cout} !== {1'b1, 1'b0, e.s, e.c}) begin
        n_err++;
        $display("FAIL backpressure_hold[%0d]: ov=%b rdy=%b sum=%h/%b want 1/0 %h/%b", i,
                 out_valid, in_ready, sum, cout, e.s, e.c);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL backpressure_release: rdy=%b ov=%b want 1 0", in_ready, out_valid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    exp_t e;
    start_op(64'h5555_5555_5555_5555, 64'h3333_3333_3333_3333, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb.pop_back());
    n_cmp++;
    if ({in_ready, out_valid, sum, cout, add_a, add_b} !==
        {1'b1, 1'b0, 64'd0, 1'b0, 16'd0, 16'd0}) begin
      n_err++;
      $display("FAIL reset_mid: rdy=%b ov=%b sum=%h cout=%b aa=%h ab=%h want 1 0 0 0 0 0",
               in_ready, out_valid, sum, cout, add_a, add_b);
    end
    start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b1, 1'b0);
    wait_result(lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== 4 || {sum, cout} !== {e.s, e.c}) begin
      n_err++;
      $display("FAIL reset_mid_fresh: lat=%0d got %h/%b want 4 %h/%b", lat, sum, cout, e.s,
               e.c);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    exp_t e;
    out_ready = 1'b1;
    start_op(64'd0, 64'd0, 1'b0, 1'b0);
    in_valid = 1'b1;
    a = 64'd1; b = 64'd1;
    sb.push_back('{s: 64'd2, c: 1'b0});
    wait_result(lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== 4 || {sum, cout} !== {e.s, e.c}) begin
      n_err++;
      $display("FAIL b2b_first: lat=%0d got %h/%b want 4 %h/%b", lat, sum, cout, e.s, e.c);
    end
    step();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_idle_gap: rdy=%b ov=%b want 1 0", in_ready, out_valid);
    end
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second_accept: rdy=%b want 0", in_ready);
    end
    wait_result(lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== 4 || {sum, cout} !== {e.s, e.c} || sum !== 64'd2) begin
      n_err++;
      $display("FAIL b2b_second: lat=%0d got %h/%b want 4 %h/%b", lat, sum, cout, e.s, e.c);
    end
    step();
    out_ready = 1'b0;
  endtask

`ifdef SUMATOR_CTRL_SUB_EN
  task automatic test_sub();
    int lat;
    exp_t e;
    start_op(64'd5, 64'd7, 1'b0, 1'b1);
    wait_result(lat);
    e = sb.pop_front();
    n_cmp++;
    if ({sum, cout} !== {e.s, e.c} || {sum, cout} !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0}) begin
      n_err++;
      $display("FAIL sub_5_7: got %h/%b want %h/%b", sum, cout, e.s, e.c);
    end
    release_result();
    start_op(64'd7, 64'd5, 1'b1, 1'b1);
    wait_result(lat);
    e = sb.pop_front();
    n_cmp++;
    if ({sum, cout} !== {e.s, e.c} || {sum, cout} !== {64'd2, 1'b1}) begin
      n_err++;
      $display("FAIL sub_7_5: got %h/%b want %h/%b", sum, cout, e.s, e.c);
    end
    release_result();
  endtask
`endif

  initial begin
    test_reset();
    test_ripple();
    test_mixed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef SUMATOR_CTRL_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
